// File: rtl/anspwm_pkg.sv
// Shared constants and types for the LED selector key/auto-toggle logic.
package anspwm_pkg;

  localparam logic SEL_SUM       = 1'b0;
  localparam logic SEL_CONTRIB   = 1'b1;
  localparam logic KEY_PRESSED_N = 1'b0;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/sel_key_toggle_debounce.sv
// Key synchronizer plus debounce FSM.
//
// state        | meaning
// -------------+-------------------------------------------------
// RELEASED     | key stably released, key_level = 0
// PRESS_WAIT   | key seen low, counting stable-low cycles
// PRESSED      | key stably pressed, key_level = 1
// RELEASE_WAIT | key seen high, counting stable-high cycles
//
// press_pulse is decoded from registered state only, so it is high on the
// cycle before the edge that enters PRESSED; the top registers the toggle on
// that same edge.
module key_debounce
  import anspwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             key_s_q;
  key_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  // Two-flop synchronizer; reset to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
    end
  end

  logic key_down;
  assign key_down = (key_s_q == KEY_PRESSED_N);

  // Debounce FSM with terminal-count compare on the stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      unique case (state_q)
        RELEASED: begin
          if (key_down) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!key_down) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!key_down) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (key_down) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_pulse = (state_q == PRESS_WAIT) && key_down && (cnt_q == DB_LAST);
  assign key_level   = level_q;

endmodule

// File: rtl/sel_key_toggle.sv
// Selector toggle for the LED display: debounced key press or periodic
// auto expiry flips sel; sel_changed pulses on every flip.
module sel_key_toggle
  import anspwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_CYCLES     = 100_000_000,
  parameter int CNT_W           = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic auto_en,
  output logic sel,
  output logic sel_changed,
  output logic key_level
);

  localparam bit               AUTO_OK   = (AUTO_CYCLES > 0);
  localparam int               AUTO_LAST = AUTO_OK ? AUTO_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] AUTO_TC   = CNT_W'(AUTO_LAST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             press_pulse;
  logic             sel_q;
  logic             chg_q;
  logic [CNT_W-1:0] auto_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .press_pulse(press_pulse)
  );

  logic auto_act;
  logic auto_exp;
  logic toggle;

  assign auto_act = auto_en && AUTO_OK;
  assign auto_exp = auto_act && (auto_q == AUTO_TC);
  assign toggle   = press_pulse || auto_exp;

  // Selector register, change pulse and auto-period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= SEL_SUM;
      chg_q  <= 1'b0;
      auto_q <= '0;
    end else begin
      chg_q <= toggle;
      if (toggle) sel_q <= ~sel_q;
      if (!auto_act || toggle) auto_q <= '0;
      else                     auto_q <= auto_q + CNT_ONE;
    end
  end

  assign sel         = sel_q;
  assign sel_changed = chg_q;

endmodule

// File: tb/tb_sel_key_toggle.sv
// Scoreboard bench for sel_key_toggle with DEBOUNCE_CYCLES=4, AUTO_CYCLES=10.
// Stimulus pushes {edge, sel} for every toggle it expects; the monitor pops
// one entry per sel_changed pulse.
module tb_sel_key_toggle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic auto_en = 1'b0;
  logic sel, sel_changed, key_level;

  typedef struct { int edge_no; logic sel_v; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  sel_key_toggle #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_CYCLES    (10),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .auto_en    (auto_en),
    .sel        (sel),
    .sel_changed(sel_changed),
    .key_level  (key_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every sel_changed pulse must match the oldest expected toggle.
  always @(negedge clk) begin
    if (sel_changed) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_toggle: pulse at edge %0d sel=%0b, none expected", cyc, sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.edge_no != cyc || e.sel_v != sel) begin
          n_fail++;
          $display("FAIL toggle: got edge %0d sel=%0b, expected edge %0d sel=%0b",
                   cyc, sel, e.edge_no, e.sel_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_edge(input int base, input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic push(input int e, input logic s);
    exp_t x;
    x.edge_no = e;
    x.sel_v   = s;
    exp_q.push_back(x);
  endtask

  task automatic chk_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected toggles missing, next at edge %0d",
               name, exp_q.size(), exp_q[0].edge_no);
      exp_q.delete();
    end
  endtask

  int base;
  logic es;
  logic [7:0] bounce;

  initial begin
    // Reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 1'b0);
    chk("rst_key_level", key_level, 1'b0);
    chk("rst_sel_changed", sel_changed, 1'b0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_sel", sel, 1'b0);
    chk("idle_key_level", key_level, 1'b0);
    es = 1'b0;

    // Clean press: toggle on edge 6.
    base = cyc; key_n = 1'b0;
    es = ~es; push(base + 6, es);
    to_edge(base, 5); chk("press_lvl_e5", key_level, 1'b0);
    to_edge(base, 6); chk("press_lvl_e6", key_level, 1'b1);
    to_edge(base, 20); chk("press_held_sel", sel, 1'b1);

    // Clean release: key_level drops on edge 6, no toggle.
    base = cyc; key_n = 1'b1;
    to_edge(base, 5); chk("rel_lvl_e5", key_level, 1'b1);
    to_edge(base, 6); chk("rel_lvl_e6", key_level, 1'b0);
    to_edge(base, 20); chk("rel_sel", sel, 1'b1);
    chk_drained("press_release");

    // Bounces of 3 low cycles never qualify.
    bounce = 8'b1000_1000;
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      key_n = bounce[i];
      to_edge(base, i + 1);
    end
    key_n = 1'b1;
    to_edge(base, 28);
    chk("bounce_lvl", key_level, 1'b0);
    chk("bounce_sel", sel, 1'b1);

    // Auto mode: toggles on edges 10, 20, 30, then disabled.
    base = cyc; auto_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin es = ~es; push(base + 10 * k, es); end
    to_edge(base, 31); auto_en = 1'b0;
    to_edge(base, 60);
    chk("auto_sel", sel, es);
    chk_drained("auto");

    // Press accepted on edge 7 restarts the auto period: next at 17.
    base = cyc; auto_en = 1'b1;
    to_edge(base, 1); key_n = 1'b0;
    es = ~es; push(base + 7, es);
    es = ~es; push(base + 17, es);
    to_edge(base, 18); auto_en = 1'b0; key_n = 1'b1;
    to_edge(base, 40);
    chk("press_auto_lvl", key_level, 1'b0);
    chk_drained("press_auto");

    // Reset on edge 4 while key held discards progress.
    base = cyc; key_n = 1'b0;
    to_edge(base, 3); rst = 1'b1;
    to_edge(base, 4);
    chk("midrst_sel", sel, 1'b0);
    chk("midrst_lvl", key_level, 1'b0);
    rst = 1'b0; es = 1'b0;
    es = ~es; push(base + 10, es);
    to_edge(base, 9); chk("midrst_lvl_e9", key_level, 1'b0);
    to_edge(base, 10); chk("midrst_lvl_e10", key_level, 1'b1);
    to_edge(base, 20);
    key_n = 1'b1;
    to_edge(base, 40);
    chk_drained("midrst");

    // Press acceptance coincides with auto expiry on edge 10: one toggle.
    base = cyc; auto_en = 1'b1;
    to_edge(base, 4); key_n = 1'b0;
    es = ~es; push(base + 10, es);
    es = ~es; push(base + 20, es);
    to_edge(base, 21); auto_en = 1'b0; key_n = 1'b1;
    to_edge(base, 45);
    chk("coinc_sel", sel, es);
    chk("coinc_lvl", key_level, 1'b0);
    chk_drained("coincident");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
